// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Purpose  : Shared definitions for the UART receiver: state encoding,
//             default oversampling ratio and a ceiling-log2 helper used to
//             size the tick and bit counters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Oversampling ratio produced by the companion baud-rate generator.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Receiver state encoding.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    // Ceiling log2, evaluated at elaboration time for counter widths.
    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_synchronizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_bit_synchronizer
//  Purpose  : Two-flop synchroniser bringing an asynchronous single-bit
//             signal into the i_clk domain. Both flops reset to RESET_VAL.
//  Ports    : i_clk  - destination clock
//             i_rst  - asynchronous active-high reset
//             i_d    - asynchronous input
//             o_q    - synchronised output (2 cycles of latency)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_bit_synchronizer #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver for 8N1-style frames. Detects the
//             start bit, samples every bit at mid-bit, shifts data in LSB
//             first and checks the stop bit.
//  Ports    : i_clk       - system clock
//             i_rst       - asynchronous active-high reset
//             i_tick      - one-cycle oversample tick
//             i_rx        - raw serial line (idle high, asynchronous)
//             o_data      - last received word, held until next frame ends
//             o_rx_done   - one-cycle pulse, good stop bit
//             o_frame_err - one-cycle pulse, stop bit sampled low
//             o_busy      - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TICK_W = clog2(OVERSAMPLE);
    localparam int BIT_W  = clog2(DATA_BITS);

    // MID lands in the middle of the start bit; LAST is one full bit later.
    localparam logic [TICK_W-1:0] MID      = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST     = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic                 rx_s;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data;
    logic                 rx_done;
    logic                 frame_err;

    // Datapath controls decoded from the current state
    logic tick_clr, tick_inc, bit_clr, bit_inc, shift_en, load_data;
    logic done_set, err_set;
    logic at_mid, at_last;

    uart_rx_bit_synchronizer #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    assign at_mid  = i_tick && (tick_cnt == MID);
    assign at_last = i_tick && (tick_cnt == LAST);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; everything except WAIT_IDLE moves only on a tick
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (i_tick && !rx_s) next_state = START;
            START:     if (at_mid) next_state = rx_s ? IDLE : DATA;
            DATA:      if (at_last && (bit_cnt == BIT_LAST)) next_state = STOP;
            STOP:      if (at_last) next_state = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        tick_clr  = 1'b0;
        tick_inc  = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        load_data = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (i_tick && !rx_s) tick_clr = 1'b1;
            end
            START: begin
                if (at_mid) begin
                    tick_clr = 1'b1;
                    bit_clr  = 1'b1;
                end else if (i_tick) begin
                    tick_inc = 1'b1;
                end
            end
            DATA: begin
                if (at_last) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    bit_inc  = (bit_cnt != BIT_LAST);
                end else if (i_tick) begin
                    tick_inc = 1'b1;
                end
            end
            STOP: begin
                if (at_last) begin
                    tick_clr  = 1'b1;
                    load_data = 1'b1;
                    done_set  = rx_s;
                    err_set   = !rx_s;
                end else if (i_tick) begin
                    tick_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counters, shift register and registered strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (tick_clr) begin
                tick_cnt <= '0;
            end else if (tick_inc) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (shift_en) begin
                shift <= {rx_s, shift[DATA_BITS-1:1]};
            end
            if (load_data) begin
                data <= shift;
            end
            rx_done   <= done_set;
            frame_err <= err_set;
        end
    end

    assign o_data      = data;
    assign o_rx_done   = rx_done;
    assign o_frame_err = frame_err;
    assign o_busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. A serial transmitter model
//             drives frames; a scoreboard compares the strobes seen on the
//             outputs against what each transmitted frame should produce.
//             The oversample tick comes every TICK_DIV clocks so that a bit
//             period is OVERSAMPLE*TICK_DIV clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
    localparam int BIT_FAST   = (BIT_CLKS * 97) / 100;       // -3 %
    localparam int BIT_SLOW   = (BIT_CLKS * 103 + 99) / 100; // +3 %

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 tick = 1'b0;
    logic                 rx = 1'b1;
    logic [DATA_BITS-1:0] data;
    logic                 rx_done;
    logic                 frame_err;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int tick_div = 0;

    // Scoreboard entries: {frame_err, rx_done, data}
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tick      (tick),
        .i_rx        (rx),
        .o_data      (data),
        .o_rx_done   (rx_done),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    // Oversample tick: one clock high every TICK_DIV clocks
    initial begin
        forever begin
            @(negedge clk);
            tick = (tick_div == TICK_DIV - 1);
            tick_div = (tick_div + 1) % TICK_DIV;
        end
    end

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_done === 1'b1 || frame_err === 1'b1)
            obs_q.push_back({frame_err, rx_done, data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(negedge clk);
    endtask

    // Transmit one frame and record the strobe it must produce.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int clks);
        send_bit(1'b0, clks);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], clks);
        send_bit(stop, clks);
        exp_q.push_back({~stop, stop, d});
    endtask

    // Compare observed strobes with expected ones, then empty both queues.
    task automatic score(input string tag);
        int n;
        logic [9:0] last;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_frame"}, 32'(obs_q[i]), 32'(exp_q[i]));
        if (exp_q.size() > 0) begin
            last = exp_q[exp_q.size() - 1];
            check({tag, "_held"}, 32'(data), 32'(last[7:0]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] abort_byte;
        logic [7:0] rnd_byte;
        logic       rnd_stop;
        int         rnd_clks;

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h0);
        check("reset_done", 32'(rx_done), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        send_bit(1'b1, BIT_CLKS);

        // Single good frame
        send_frame(8'h55, 1'b1, BIT_CLKS);
        send_bit(1'b1, BIT_CLKS);
        score("t1_55");

        // Back-to-back frames with no idle gap
        send_frame(8'hA3, 1'b1, BIT_CLKS);
        send_frame(8'h0F, 1'b1, BIT_CLKS);
        send_bit(1'b1, BIT_CLKS);
        score("t2_b2b");

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        check("t3_busy_glitch", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (8 * TICK_DIV) @(negedge clk);
        check("t3_busy_clear", 32'(busy), 32'h0);
        send_bit(1'b1, BIT_CLKS);
        score("t3_glitch");

        // Framing error, then a held-low break, then a good frame
        send_frame(8'h81, 1'b0, BIT_CLKS);
        send_bit(1'b0, 3 * BIT_CLKS);
        check("t4_busy_break", 32'(busy), 32'h1);
        score("t4_err");
        send_bit(1'b1, BIT_CLKS);
        check("t4_busy_after", 32'(busy), 32'h0);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        send_bit(1'b1, BIT_CLKS);
        score("t4_after");

        // Reset in the middle of data bit 4
        abort_byte = 8'hE7;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(abort_byte[i], BIT_CLKS);
        rx = abort_byte[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_data", 32'(data), 32'h0);
        check("t5_rst_done", 32'(rx_done), 32'h0);
        check("t5_rst_err", 32'(frame_err), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b0;
        for (int i = 5; i < DATA_BITS; i++) send_bit(abort_byte[i], BIT_CLKS);
        send_bit(1'b1, 2 * BIT_CLKS);
        score("t5_abort");
        check("t5_data_kept", 32'(data), 32'h0);
        send_frame(8'hC6, 1'b1, BIT_CLKS);
        send_bit(1'b1, BIT_CLKS);
        score("t5_after");

        // Baud skew of +3 % and -3 %
        send_frame(8'h96, 1'b1, BIT_SLOW);
        send_bit(1'b1, BIT_CLKS);
        score("t6_slow");
        send_frame(8'h96, 1'b1, BIT_FAST);
        send_bit(1'b1, BIT_CLKS);
        score("t6_fast");

        // Randomised frames, random stop bit and skew
        for (int k = 0; k < 8; k++) begin
            rnd_byte = 8'($urandom);
            rnd_stop = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       rnd_clks = BIT_FAST;
                1:       rnd_clks = BIT_CLKS;
                default: rnd_clks = BIT_SLOW;
            endcase
            send_frame(rnd_byte, rnd_stop, rnd_clks);
            send_bit(1'b1, BIT_CLKS);
            score("t7_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
